// File: rtl/wordle_pkg.sv
// Shared types and constants for the Wordle scoring stage: letter geometry,
// one-hot FSM states and the 2-bit colour codes.
package wordle_pkg;

    localparam int LW = 8;
    localparam int NL = 5;

    typedef enum logic [3:0] {
        QI      = 4'b1000,
        QGREEN  = 4'b0100,
        QYELLOW = 4'b0010,
        QDONE   = 4'b0001
    } state_e;

    localparam logic [1:0] GRAY   = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    // Position 0 is the first letter and sits in the most significant byte.
    function automatic logic [LW-1:0] letter_at(input logic [LW*NL-1:0] w, input int i);
        return w[LW*(NL-1-i) +: LW];
    endfunction

endpackage

// File: rtl/wordle_scorer_if.sv
// Request/result bundle between the game FSM (master) and the scorer (slave).
interface wordle_scorer_if;

    logic                                     Start;
    logic                                     Ack;
    logic [wordle_pkg::LW*wordle_pkg::NL-1:0] guess;
    logic [wordle_pkg::LW*wordle_pkg::NL-1:0] target;
    logic [2*wordle_pkg::NL-1:0]              colors;
    logic                                     win;
    logic                                     q_I;
    logic                                     q_Green;
    logic                                     q_Yellow;
    logic                                     q_Done;

    modport master (
        output Start, Ack, guess, target,
        input  colors, win, q_I, q_Green, q_Yellow, q_Done
    );

    modport slave (
        input  Start, Ack, guess, target,
        output colors, win, q_I, q_Green, q_Yellow, q_Done
    );

endinterface

// File: rtl/wordle_match_finder.sv
// Finds the lowest target position holding a given letter that has not yet
// been credited; hit_o is one-hot (bit 0 = first letter).
module wordle_match_finder
    import wordle_pkg::*;
(
    input  logic [LW-1:0]    letter_i,
    input  logic [LW*NL-1:0] target_i,
    input  logic [NL-1:0]    used_i,
    output logic             found_o,
    output logic [NL-1:0]    hit_o
);

    logic [NL-1:0] cand;
    logic          seen;

    always_comb begin
        hit_o = '0;
        seen  = 1'b0;
        for (int k = 0; k < NL; k++) begin
            cand[k] = !used_i[k] && (letter_at(target_i, k) == letter_i);
            if (cand[k] && !seen) begin
                hit_o[k] = 1'b1;
                seen     = 1'b1;
            end
        end
        found_o = seen;
    end

endmodule

// File: rtl/wordle_scorer.sv
// Scores a five-letter guess against the word of the day: one green pass,
// then one yellow lookup per position, left to right.
//
// state   | meaning
// QI      | idle, previous colours retained, waiting for Start
// QGREEN  | exact-position matches credited for all letters at once
// QYELLOW | position j_q searched for an uncredited match elsewhere
// QDONE   | result held until Ack
module wordle_scorer
    import wordle_pkg::*;
(
    input  logic          Clk,
    input  logic          reset,
    wordle_scorer_if.slave bus
);

    state_e              state_q;
    logic [LW*NL-1:0]    g_q;
    logic [LW*NL-1:0]    t_q;
    logic [2*NL-1:0]     colors_q;
    logic [NL-1:0]       used_q;
    logic [2:0]          j_q;

    logic [LW-1:0]       g_sel;
    logic                j_green;
    logic                found;
    logic [NL-1:0]       hit;

    always_comb begin
        g_sel   = '0;
        j_green = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (j_q == 3'(i)) begin
                g_sel   = letter_at(g_q, i);
                j_green = (colors_q[2*(NL-1-i) +: 2] == GREEN);
            end
        end
    end

    wordle_match_finder u_match (
        .letter_i (g_sel),
        .target_i (t_q),
        .used_i   (used_q),
        .found_o  (found),
        .hit_o    (hit)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q  <= QI;
            g_q      <= '0;
            t_q      <= '0;
            colors_q <= '0;
            used_q   <= '0;
            j_q      <= '0;
        end else begin
            case (state_q)
                QI: begin
                    if (bus.Start) begin
                        g_q      <= bus.guess;
                        t_q      <= bus.target;
                        colors_q <= {NL{GRAY}};
                        used_q   <= '0;
                        state_q  <= QGREEN;
                    end
                end
                QGREEN: begin
                    for (int i = 0; i < NL; i++) begin
                        if (letter_at(g_q, i) == letter_at(t_q, i)) begin
                            colors_q[2*(NL-1-i) +: 2] <= GREEN;
                            used_q[i]                 <= 1'b1;
                        end
                    end
                    j_q     <= '0;
                    state_q <= QYELLOW;
                end
                QYELLOW: begin
                    if (j_q > 3'(NL-1)) begin
                        state_q <= QDONE;
                    end else begin
                        for (int i = 0; i < NL; i++) begin
                            if (j_q == 3'(i) && !j_green && found) begin
                                colors_q[2*(NL-1-i) +: 2] <= YELLOW;
                            end
                        end
                        if (!j_green && found) used_q <= used_q | hit;
                        j_q <= j_q + 3'd1;
                        if (j_q == 3'(NL-1)) state_q <= QDONE;
                    end
                end
                QDONE: begin
                    if (bus.Ack) state_q <= QI;
                end
                default: state_q <= QI;
            endcase
        end
    end

    assign bus.colors   = colors_q;
    assign bus.q_I      = state_q[3];
    assign bus.q_Green  = state_q[2];
    assign bus.q_Yellow = state_q[1];
    assign bus.q_Done   = state_q[0];
    assign bus.win      = (state_q == QDONE) && (colors_q == {NL{GREEN}});

endmodule

// File: tb/tb_wordle_scorer.sv
// Directed bench for wordle_scorer: scoring vectors, duplicate-letter rules,
// handshake corner cases, mid-operation reset and input hold after Start.
module tb_wordle_scorer;

    logic Clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   cyc;
    logic [9:0] snap;

    wordle_scorer_if bus ();

    wordle_scorer dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for q_Done with a cycle budget; returns clocks spent.
    task automatic wait_done(output int c);
        c = 0;
        while (bus.q_Done !== 1'b1 && c < 20) begin
            step();
            c++;
        end
    endtask

    task automatic score(input string tag, input logic [39:0] g, input logic [39:0] t);
        int c;
        bus.guess  = g;
        bus.target = t;
        bus.Start  = 1'b1;
        step();
        bus.Start = 1'b0;
        wait_done(c);
        chk({tag, "_latency"}, 32'(c), 32'd6);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.Start  = 1'b0;
        bus.Ack    = 1'b0;
        bus.guess  = '0;
        bus.target = '0;
        step();
        step();
        chk("rst_qI",     32'(bus.q_I),      32'd1);
        chk("rst_flags",  32'({bus.q_Green, bus.q_Yellow, bus.q_Done}), 32'd0);
        chk("rst_colors", 32'(bus.colors),   32'd0);
        chk("rst_win",    32'(bus.win),      32'd0);
        reset = 1'b0;
        step();

        // Exact match
        score("robot", "ROBOT", "ROBOT");
        chk("robot_colors", 32'(bus.colors), 32'b1010101010);
        chk("robot_win",    32'(bus.win),    32'd1);
        bus.Ack = 1'b1; step(); bus.Ack = 1'b0;
        chk("robot_ack_qI", 32'(bus.q_I), 32'd1);
        chk("robot_retain", 32'(bus.colors), 32'b1010101010);
        chk("robot_win_qI", 32'(bus.win), 32'd0);
        step();

        score("floor", "FLOOR", "ROBOT");
        chk("floor_colors", 32'(bus.colors), 32'b0000011001);
        chk("floor_win",    32'(bus.win),    32'd0);
        bus.Ack = 1'b1; step(); bus.Ack = 1'b0;

        score("bbbbb", "BBBBB", "ABBOT");
        chk("bbbbb_colors", 32'(bus.colors), 32'b0010100000);
        bus.Ack = 1'b1; step(); bus.Ack = 1'b0;

        score("aaaaa", "AAAAA", "CACAO");
        chk("aaaaa_colors", 32'(bus.colors), 32'b0010001000);

        // Hold in QDONE without Ack
        snap = bus.colors;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_done",   32'(bus.q_Done), 32'd1);
            chk("hold_colors", 32'(bus.colors), 32'(snap));
        end

        // Start and Ack together in QDONE: only Ack acts
        bus.Ack   = 1'b1;
        bus.Start = 1'b1;
        step();
        chk("both_done_qI", 32'(bus.q_I), 32'd1);
        // Start and Ack together in QI: only Start acts
        bus.guess  = "FLOOR";
        bus.target = "ROBOT";
        step();
        bus.Ack   = 1'b0;
        bus.Start = 1'b0;
        chk("both_qi_green", 32'(bus.q_Green), 32'd1);
        step();
        step();
        chk("yellow_state", 32'(bus.q_Yellow), 32'd1);
        // Start pulse during QYELLOW must be ignored
        bus.guess  = "ROBOT";
        bus.Start  = 1'b1;
        step();
        bus.Start = 1'b0;
        wait_done(cyc);
        chk("pulse_latency", 32'(cyc), 32'd3);
        chk("pulse_colors",  32'(bus.colors), 32'b0000011001);
        chk("pulse_win",     32'(bus.win),    32'd0);
        bus.Ack = 1'b1; step(); bus.Ack = 1'b0;
        chk("b2b_qI", 32'(bus.q_I), 32'd1);

        // Reset with J=2 in QYELLOW
        bus.guess  = "ROBOT";
        bus.target = "ROBOT";
        bus.Start  = 1'b1;
        step();
        bus.Start = 1'b0;
        step(); step(); step();
        chk("mid_yellow", 32'(bus.q_Yellow), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_qI",     32'(bus.q_I),    32'd1);
        chk("mid_rst_colors", 32'(bus.colors), 32'd0);
        chk("mid_rst_win",    32'(bus.win),    32'd0);
        score("lapse", "LAPSE", "LAPSE");
        chk("lapse_win", 32'(bus.win), 32'd1);
        bus.Ack = 1'b1; step(); bus.Ack = 1'b0;

        // Inputs change right after the Start edge
        bus.guess  = "STOVE";
        bus.target = "STOVE";
        bus.Start  = 1'b1;
        step();
        bus.Start  = 1'b0;
        bus.guess  = "XXXXX";
        bus.target = "QQQQQ";
        wait_done(cyc);
        chk("stove_latency", 32'(cyc), 32'd6);
        chk("stove_colors",  32'(bus.colors), 32'b1010101010);
        chk("stove_win",     32'(bus.win),    32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
